// File: rtl/tl_demux.sv
// 1-to-N response router: steers a valid/ready beat stream to one of N clients,
// locking multi-beat messages to the destination sampled on their first beat.
module tl_demux #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              last_i,
    output logic [N-1:0]      valid_o,
    input  logic [N-1:0]      ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              drop_o
);

    localparam int SPAN = 1 << SEL_W;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  locked_sel_q, locked_sel_d;

    logic              out_valid_q;
    logic [SEL_W-1:0]  out_sel_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic              drop_q;

    logic [SPAN-1:0]   ready_pad;
    logic [SPAN-1:0]   dest_mask;
    logic [SEL_W-1:0]  route;
    logic              route_ok;
    logic              sel_ready;
    logic              fire;
    logic              accept;
    logic              load;

    // Pad ready_i and build the legal-destination mask to the full index span,
    // so unused encodings (N not a power of two) index cleanly.
    always_comb begin
        ready_pad = '0;
        ready_pad[N-1:0] = ready_i;
        dest_mask = '0;
        for (int k = 0; k < SPAN; k++) begin
            dest_mask[k] = (k < N);
        end
    end

    always_comb begin
        route     = (state_q == BURST) ? locked_sel_q : sel_i;
        route_ok  = dest_mask[route];
        sel_ready = ready_pad[out_sel_q];
        fire      = out_valid_q && sel_ready;
        ready_o   = !out_valid_q || sel_ready || !route_ok;
        accept    = valid_i && ready_o;
        load      = accept && route_ok;
    end

    always_comb begin
        state_d      = state_q;
        locked_sel_d = locked_sel_q;
        case (state_q)
            IDLE: begin
                if (accept && !last_i) begin
                    state_d      = BURST;
                    locked_sel_d = sel_i;
                end
            end
            BURST: begin
                if (accept && last_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            locked_sel_q <= '0;
        end else begin
            state_q      <= state_d;
            locked_sel_q <= locked_sel_d;
        end
    end

    // Dropped beats never touch the output register, which keeps draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= accept && !route_ok;
            if (load) begin
                out_valid_q <= 1'b1;
                out_sel_q   <= route;
                out_data_q  <= data_i;
                out_last_q  <= last_i;
            end else if (fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        valid_o = '0;
        for (int k = 0; k < N; k++) begin
            valid_o[k] = out_valid_q && (out_sel_q == SEL_W'(k));
        end
    end

    assign data_o = out_data_q;
    assign last_o = out_last_q;
    assign busy_o = (state_q == BURST);
    assign drop_o = drop_q;

endmodule

// File: tb/tb_tl_demux.sv
// Bench for tl_demux: a 4-client and a 3-client instance, directed vector table,
// hand-written reset sequence, then random traffic against a transaction model.
module tb_tl_demux;

    logic clk;
    logic rst_n;

    logic       in_valid [2];
    logic [1:0] in_sel   [2];
    logic [7:0] in_data  [2];
    logic       in_last  [2];
    logic [3:0] in_ready [2];

    logic       ready4, ready3;
    logic [3:0] valid4;
    logic [2:0] valid3;
    logic [7:0] data4, data3;
    logic       last4, last3, busy4, busy3, drop4, drop3;

    logic       obs_ready [2];
    logic [3:0] obs_valid [2];
    logic [7:0] obs_data  [2];
    logic       obs_last  [2];
    logic       obs_busy  [2];
    logic       obs_drop  [2];

    int tests  = 0;
    int failed = 0;

    tl_demux #(.N(4), .DATA_W(8), .SEL_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .valid_i(in_valid[0]), .ready_o(ready4), .data_i(in_data[0]),
        .sel_i(in_sel[0]), .last_i(in_last[0]),
        .valid_o(valid4), .ready_i(in_ready[0]), .data_o(data4),
        .last_o(last4), .busy_o(busy4), .drop_o(drop4)
    );

    tl_demux #(.N(3), .DATA_W(8), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .valid_i(in_valid[1]), .ready_o(ready3), .data_i(in_data[1]),
        .sel_i(in_sel[1]), .last_i(in_last[1]),
        .valid_o(valid3), .ready_i(in_ready[1][2:0]), .data_o(data3),
        .last_o(last3), .busy_o(busy3), .drop_o(drop3)
    );

    always_comb begin
        obs_ready[0] = ready4;           obs_ready[1] = ready3;
        obs_valid[0] = valid4;           obs_valid[1] = {1'b0, valid3};
        obs_data[0]  = data4;            obs_data[1]  = data3;
        obs_last[0]  = last4;            obs_last[1]  = last3;
        obs_busy[0]  = busy4;            obs_busy[1]  = busy3;
        obs_drop[0]  = drop4;            obs_drop[1]  = drop3;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         d;
        logic       v;
        logic [1:0] sel;
        logic [7:0] data;
        logic       last;
        logic [3:0] rdy;
        logic       e_ready;
        logic [3:0] e_valid;
        logic [7:0] e_data;
        logic       e_last;
        logic       e_busy;
        logic       e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int d, logic v, logic [1:0] sel, logic [7:0] data,
                                logic last, logic [3:0] rdy, logic e_ready,
                                logic [3:0] e_valid, logic [7:0] e_data,
                                logic e_last, logic e_busy, logic e_drop);
        vec_t r;
        r = '{d, v, sel, data, last, rdy, e_ready, e_valid, e_data, e_last, e_busy, e_drop};
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic v, input logic [1:0] sel,
                                 input logic [7:0] data, input logic last, input logic [3:0] rdy);
        in_valid[d] = v;
        in_sel[d]   = sel;
        in_data[d]  = data;
        in_last[d]  = last;
        in_ready[d] = rdy;
    endtask

    task automatic idleAll();
        for (int d = 0; d < 2; d++) applyStimulus(d, 1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    endtask

    // Transaction-level model: at most one buffered beat plus the message's destination.
    bit         m_full   [2];
    int         m_sel    [2];
    logic [7:0] m_data   [2];
    logic       m_last   [2];
    bit         m_in_msg [2];
    int         m_dest   [2];
    bit         m_drop   [2];
    bit         m_acc    [2];
    int         n_cli    [2] = '{4, 3};

    function automatic int modelDest(int d);
        return m_in_msg[d] ? m_dest[d] : int'(in_sel[d]);
    endfunction

    function automatic bit modelReady(int d);
        if (!m_full[d]) return 1'b1;
        if (in_ready[d][m_sel[d]]) return 1'b1;
        return modelDest(d) >= n_cli[d];
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            m_full[d] = 0; m_in_msg[d] = 0; m_drop[d] = 0; m_acc[d] = 0;
            m_sel[d] = 0; m_dest[d] = 0; m_data[d] = '0; m_last[d] = 0;
        end
    endtask

    task automatic modelStep(int d);
        int dest;
        bit ok;
        dest = modelDest(d);
        ok   = dest < n_cli[d];
        m_drop[d] = m_acc[d] && !ok;
        if (m_acc[d] && ok) begin
            m_full[d] = 1; m_sel[d] = dest; m_data[d] = in_data[d]; m_last[d] = in_last[d];
        end else if (m_full[d] && in_ready[d][m_sel[d]]) begin
            m_full[d] = 0;
        end
        if (m_acc[d]) begin
            if (!m_in_msg[d] && !in_last[d]) begin
                m_in_msg[d] = 1;
                m_dest[d]   = int'(in_sel[d]);
            end else if (m_in_msg[d] && in_last[d]) begin
                m_in_msg[d] = 0;
            end
        end
    endtask

    initial begin
        idleAll();
        rst_n = 1'b0;
        #12;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset dut%0d valid_o", d), 32'(obs_valid[d]), 32'h0);
            checkOutput($sformatf("reset dut%0d data_o", d),  32'(obs_data[d]), 32'h0);
            checkOutput($sformatf("reset dut%0d last_o", d),  32'(obs_last[d]), 32'h0);
            checkOutput($sformatf("reset dut%0d busy_o", d),  32'(obs_busy[d]), 32'h0);
            checkOutput($sformatf("reset dut%0d drop_o", d),  32'(obs_drop[d]), 32'h0);
            checkOutput($sformatf("reset dut%0d ready_o", d), 32'(obs_ready[d]), 32'h1);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, back-to-back, burst lock, backpressure on the 4-client instance
        vecs.push_back(mk(0, 1, 2, 8'hA2, 1, 4'hF, 1, 4'b0100, 8'hA2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 4'hF, 1, 4'b0000, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'hA0, 1, 4'hF, 1, 4'b0001, 8'hA0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hA1, 1, 4'hF, 1, 4'b0010, 8'hA1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2, 8'hA2, 1, 4'hF, 1, 4'b0100, 8'hA2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 3, 8'hA3, 1, 4'hF, 1, 4'b1000, 8'hA3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 4'hF, 1, 4'b0000, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hB0, 0, 4'hF, 1, 4'b0010, 8'hB0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 3, 8'hB1, 0, 4'hF, 1, 4'b0010, 8'hB1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 3, 8'hB2, 1, 4'hF, 1, 4'b0010, 8'hB2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 4'hF, 1, 4'b0000, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 8'hC0, 1, 4'b1011, 1, 4'b0100, 8'hC0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hC1, 1, 4'b1011, 0, 4'b0100, 8'hC0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hC1, 1, 4'b1011, 0, 4'b0100, 8'hC0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hC1, 1, 4'b1011, 0, 4'b0100, 8'hC0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hC1, 1, 4'hF,    1, 4'b0010, 8'hC1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 4'hF,    1, 4'b0000, 8'h00, 0, 0, 0));
        // Invalid destination on the 3-client instance
        vecs.push_back(mk(1, 1, 3, 8'hD0, 0, 4'h7, 1, 4'b0000, 8'h00, 0, 1, 1));
        vecs.push_back(mk(1, 1, 3, 8'hD1, 1, 4'h7, 1, 4'b0000, 8'h00, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 8'hD2, 1, 4'h7, 1, 4'b0001, 8'hD2, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h7, 1, 4'b0000, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'hE0, 1, 4'h0, 1, 4'b0010, 8'hE0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 3, 8'hE1, 1, 4'h0, 1, 4'b0010, 8'hE0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 2, 8'hE2, 1, 4'h0, 0, 4'b0010, 8'hE0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 2, 8'hE2, 1, 4'h7, 1, 4'b0100, 8'hE2, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h7, 1, 4'b0000, 8'h00, 0, 0, 0));

        foreach (vecs[i]) begin
            idleAll();
            applyStimulus(vecs[i].d, vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].last, vecs[i].rdy);
            #3;
            checkOutput($sformatf("vec%0d ready_o", i), 32'(obs_ready[vecs[i].d]), 32'(vecs[i].e_ready));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d valid_o", i), 32'(obs_valid[vecs[i].d]), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid != 4'b0000) begin
                checkOutput($sformatf("vec%0d data_o", i), 32'(obs_data[vecs[i].d]), 32'(vecs[i].e_data));
                checkOutput($sformatf("vec%0d last_o", i), 32'(obs_last[vecs[i].d]), 32'(vecs[i].e_last));
            end
            checkOutput($sformatf("vec%0d busy_o", i), 32'(obs_busy[vecs[i].d]), 32'(vecs[i].e_busy));
            checkOutput($sformatf("vec%0d drop_o", i), 32'(obs_drop[vecs[i].d]), 32'(vecs[i].e_drop));
        end

        // Reset in the middle of a 4-beat message
        idleAll();
        applyStimulus(0, 1'b1, 2'd1, 8'hF0, 1'b0, 4'hF);
        @(posedge clk);
        #1;
        checkOutput("midrst pre busy_o", 32'(busy4), 32'h1);
        checkOutput("midrst pre valid_o", 32'(valid4), 32'b0010);
        applyStimulus(0, 1'b1, 2'd1, 8'hF1, 1'b0, 4'hF);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst valid_o", 32'(valid4), 32'h0);
        checkOutput("midrst busy_o", 32'(busy4), 32'h0);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 2'd3, 8'h5A, 1'b1, 4'hF);
        #1;
        checkOutput("midrst post ready_o", 32'(ready4), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("midrst post valid_o", 32'(valid4), 32'b1000);
        checkOutput("midrst post data_o", 32'(data4), 32'h5A);
        checkOutput("midrst post last_o", 32'(last4), 32'h1);
        checkOutput("midrst post busy_o", 32'(busy4), 32'h0);
        idleAll();
        @(posedge clk);
        #1;
        checkOutput("midrst drain valid_o", 32'(valid4), 32'h0);

        // Random traffic on both instances against the model
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        modelReset();
        idleAll();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                if (!in_valid[d] || m_acc[d]) begin
                    in_valid[d] = ($urandom_range(0, 9) < 7);
                    in_sel[d]   = 2'($urandom_range(0, 3));
                    in_data[d]  = 8'($urandom);
                    in_last[d]  = ($urandom_range(0, 2) == 0);
                end
                for (int b = 0; b < 4; b++) in_ready[d][b] = ($urandom_range(0, 3) != 0);
            end
            #3;
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("rnd%0d dut%0d ready_o", cyc, d), 32'(obs_ready[d]), 32'(modelReady(d)));
                m_acc[d] = in_valid[d] && modelReady(d);
            end
            @(posedge clk);
            for (int d = 0; d < 2; d++) modelStep(d);
            #1;
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("rnd%0d dut%0d valid_o", cyc, d), 32'(obs_valid[d]),
                            m_full[d] ? (32'h1 << m_sel[d]) : 32'h0);
                if (m_full[d]) begin
                    checkOutput($sformatf("rnd%0d dut%0d data_o", cyc, d), 32'(obs_data[d]), 32'(m_data[d]));
                    checkOutput($sformatf("rnd%0d dut%0d last_o", cyc, d), 32'(obs_last[d]), 32'(m_last[d]));
                end
                checkOutput($sformatf("rnd%0d dut%0d busy_o", cyc, d), 32'(obs_busy[d]), 32'(m_in_msg[d]));
                checkOutput($sformatf("rnd%0d dut%0d drop_o", cyc, d), 32'(obs_drop[d]), 32'(m_drop[d]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
